multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  rising-edge clock; the single clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronised to clk externally.
REQ-003 opcode  input  7  instruction[6:0] from the instruction register; valid from DECODE onward.
REQ-004 zero  input  1  ALU zero flag; sampled only in BRANCH.
REQ-005 mem_ready  input  1  memory handshake; a memory access completes on a cycle with mem_ready=1 and its strobe asserted.
REQ-006 Outputs are all 1 bit unless stated: PCWrite, IRWrite, IorD (0=PC, 1=ALUOut), MemRead, MemWrite, RegWrite, MemtoReg, ALUSrcA (0=PC, 1=rs1), ALUSrcB[1:0] (00=rs2, 01=const 4, 10=imm), ALUOp[1:0] (00 add, 01 sub/compare, 10 funct decode), PCSrc (0=ALU result, 1=ALUOut).
REQ-007 Status outputs: retire (1-cycle pulse), illegal (1-cycle pulse), instret[15:0] (count of retired instructions), state[3:0] (current state encoding).

Function
REQ-008 State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, ALU_WB=8, BRANCH=9.
REQ-009 Any other state encoding goes to FETCH on the next edge; all strobes are 0 in that cycle.
REQ-010 FETCH outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=0.
REQ-011 FETCH behaviour: it holds while mem_ready=0. While mem_ready=1, IRWrite=1 and PCWrite=1 in that same cycle, and the next state is DECODE.
REQ-012 DECODE outputs: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target into ALUOut). No strobes.
REQ-013 DECODE latches opcode into an internal register; later states use only the latched copy.
REQ-014 DECODE transitions: 0110011→EXEC_R; 0010011→EXEC_I; 0000011 or 0100011→MEM_ADDR; 1100011→BRANCH.
REQ-015 Any other opcode in DECODE: illegal=1 for that cycle, next state FETCH, no retire, instret unchanged.
REQ-016 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state ALU_WB.
REQ-017 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state ALU_WB.
REQ-018 ALU_WB: RegWrite=1, MemtoReg=0, retire=1; next state FETCH.
REQ-019 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEM_RD for a load, MEM_WR for a store.
REQ-020 MEM_RD: MemRead=1, IorD=1; holds while mem_ready=0, goes to MEM_WB on mem_ready=1.
REQ-021 MEM_WB: RegWrite=1, MemtoReg=1, retire=1; next state FETCH.
REQ-022 MEM_WR: MemWrite=1, IorD=1; holds while mem_ready=0. On mem_ready=1: retire=1, next state FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=zero, retire=1; next state FETCH.
REQ-024 Any output not listed for a state is 0 in that state.
REQ-025 All control outputs are Moore decodes of state, except PCWrite/IRWrite in FETCH, PCWrite in BRANCH, and retire in MEM_WR.
REQ-026 instret increments by 1 on every cycle with retire=1 and wraps from 0xFFFF to 0x0000.
REQ-027 Timing: MemRead and MemWrite are never asserted in the same cycle. Strobes stay stable while a handshake is stalled.
REQ-028 Latency with mem_ready tied 1: R/I = 4 cycles, load = 5, store = 4, branch = 3.

Reset
REQ-029 While rst_n=0, asynchronously: state=FETCH, latched opcode=0, instret=0.
REQ-030 While rst_n=0, every output is 0, including the FETCH Moore outputs.
REQ-031 A reset asserted mid-instruction aborts it: no RegWrite, MemWrite, PCWrite or retire after rst_n falls.
REQ-032 The first cycle after rst_n rises is FETCH.

Verification
REQ-033 mem_ready=1, opcode 0110011 → state sequence 0,1,2,8,0; RegWrite=1 only in state 8; retire once; instret=1.
REQ-034 Load with mem_ready=0 for 3 cycles in MEM_RD → state 5 held 4 cycles with MemRead=1, IorD=1; then state 6 with RegWrite=1, MemtoReg=1.
REQ-035 BEQ with zero=1 → PCWrite=1, PCSrc=1 in state 9. Same with zero=0 → PCWrite=0; retire=1 in both cases.
REQ-036 opcode 1111111 → illegal pulse in DECODE, return to FETCH, instret unchanged.
REQ-037 Preload instret=0xFFFF via 65535 retires, then one ALU op → instret=0x0000.
REQ-038 rst_n low while in MEM_WR with mem_ready=0 → outputs 0 immediately, instret=0, FETCH after release.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle controller and its datapath.
interface multicycle_control_if;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite;
  logic        IRWrite;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic        MemtoReg;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic        PCSrc;
  logic        retire;
  logic        illegal;
  logic [15:0] instret;
  logic [3:0]  state;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, retire, illegal, instret, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, retire, illegal, instret, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM: Moore decode of state with a few
// handshake-qualified strobes, plus a retired-instruction counter.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);
  localparam int unsigned ST_W = 4;
  localparam int unsigned OP_W = 7;
  localparam int unsigned IC_W = 16;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [ST_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [IC_W-1:0] instret_q;

  logic       pc_write_c, ir_write_c, iord_c, mem_read_c, mem_write_c;
  logic       reg_write_c, memto_reg_c, alu_src_a_c, pc_src_c;
  logic [1:0] alu_src_b_c, alu_op_c;
  logic       retire_c, illegal_c;

  // State, latched opcode and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
      if (retire_c) instret_q <= instret_q + IC_W'(1);
    end
  end

  // Next state and output decode
  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    iord_c      = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    memto_reg_c = 1'b0;
    alu_src_a_c = 1'b0;
    alu_src_b_c = 2'b00;
    alu_op_c    = 2'b00;
    pc_src_c    = 1'b0;
    retire_c    = 1'b0;
    illegal_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_c = 2'b10;
        case (bus.opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (op_q == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_c = 1'b1;
        memto_reg_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
        if (bus.mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b01;
        pc_src_c    = 1'b1;
        pc_write_c  = bus.zero;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every output low, including the FETCH Moore outputs
  assign bus.PCWrite  = rst_n & pc_write_c;
  assign bus.IRWrite  = rst_n & ir_write_c;
  assign bus.IorD     = rst_n & iord_c;
  assign bus.MemRead  = rst_n & mem_read_c;
  assign bus.MemWrite = rst_n & mem_write_c;
  assign bus.RegWrite = rst_n & reg_write_c;
  assign bus.MemtoReg = rst_n & memto_reg_c;
  assign bus.ALUSrcA  = rst_n & alu_src_a_c;
  assign bus.ALUSrcB  = {2{rst_n}} & alu_src_b_c;
  assign bus.ALUOp    = {2{rst_n}} & alu_op_c;
  assign bus.PCSrc    = rst_n & pc_src_c;
  assign bus.retire   = rst_n & retire_c;
  assign bus.illegal  = rst_n & illegal_c;
  assign bus.instret  = instret_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state, control
// vector and instret are queued as stimulus is planned, then compared.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if ifc();
  multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

  // {PCWrite,IRWrite,IorD,MemRead,MemWrite,RegWrite,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,PCSrc,retire,illegal}
  localparam logic [14:0] C_ZERO   = 15'b0_0_0_0_0_0_0_0_00_00_0_0_0;
  localparam logic [14:0] C_FW     = 15'b0_0_0_1_0_0_0_0_01_00_0_0_0;
  localparam logic [14:0] C_FG     = 15'b1_1_0_1_0_0_0_0_01_00_0_0_0;
  localparam logic [14:0] C_DEC    = 15'b0_0_0_0_0_0_0_0_10_00_0_0_0;
  localparam logic [14:0] C_DECILL = 15'b0_0_0_0_0_0_0_0_10_00_0_0_1;
  localparam logic [14:0] C_EXR    = 15'b0_0_0_0_0_0_0_1_00_10_0_0_0;
  localparam logic [14:0] C_EXI    = 15'b0_0_0_0_0_0_0_1_10_00_0_0_0;
  localparam logic [14:0] C_ALUWB  = 15'b0_0_0_0_0_1_0_0_00_00_0_1_0;
  localparam logic [14:0] C_MEMRD  = 15'b0_0_1_1_0_0_0_0_00_00_0_0_0;
  localparam logic [14:0] C_MEMWB  = 15'b0_0_0_0_0_1_1_0_00_00_0_1_0;
  localparam logic [14:0] C_WRW    = 15'b0_0_1_0_1_0_0_0_00_00_0_0_0;
  localparam logic [14:0] C_WRG    = 15'b0_0_1_0_1_0_0_0_00_00_0_1_0;
  localparam logic [14:0] C_BR1    = 15'b1_0_0_0_0_0_0_1_00_01_1_1_0;
  localparam logic [14:0] C_BR0    = 15'b0_0_0_0_0_0_0_1_00_01_1_1_0;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] ctrl;
    logic [15:0] ic;
    logic        mr;
    logic        z;
    logic [6:0]  op;
  } item_t;

  item_t       sb[$];
  item_t       it;
  logic [15:0] model_instret = 16'd0;
  int          errors = 0;
  int          checks = 0;
  int          n = 0;

  function automatic logic [14:0] obs_ctrl();
    return {ifc.PCWrite, ifc.IRWrite, ifc.IorD, ifc.MemRead, ifc.MemWrite, ifc.RegWrite,
            ifc.MemtoReg, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUOp, ifc.PCSrc, ifc.retire, ifc.illegal};
  endfunction

  task automatic push(input logic [3:0] st, input logic [14:0] c, input logic mr,
                      input logic z, input logic [6:0] op);
    item_t e;
    e.st = st; e.ctrl = c; e.mr = mr; e.z = z; e.op = op; e.ic = model_instret;
    sb.push_back(e);
    if (c[1]) model_instret = model_instret + 16'd1;
  endtask

  // Plans one instruction; opcode is scrambled after DECODE to exercise the latch
  task automatic issue(input logic [6:0] op, input logic z, input int fstall, input int mstall);
    logic [6:0] alt;
    logic       legal;
    alt   = op ^ 7'h20;
    legal = (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BR);
    for (int i = 0; i < fstall; i++) push(4'd0, C_FW, 1'b0, ~z, alt);
    push(4'd0, C_FG, 1'b1, ~z, alt);
    push(4'd1, legal ? C_DEC : C_DECILL, 1'b1, ~z, op);
    case (op)
      OP_R:  begin push(4'd2, C_EXR, 1'b1, ~z, alt); push(4'd8, C_ALUWB, 1'b1, ~z, alt); end
      OP_I:  begin push(4'd3, C_EXI, 1'b1, ~z, alt); push(4'd8, C_ALUWB, 1'b1, ~z, alt); end
      OP_LD: begin
        push(4'd4, C_EXI, 1'b1, ~z, alt);
        for (int i = 0; i < mstall; i++) push(4'd5, C_MEMRD, 1'b0, ~z, alt);
        push(4'd5, C_MEMRD, 1'b1, ~z, alt);
        push(4'd6, C_MEMWB, 1'b1, ~z, alt);
      end
      OP_ST: begin
        push(4'd4, C_EXI, 1'b1, ~z, alt);
        for (int i = 0; i < mstall; i++) push(4'd7, C_WRW, 1'b0, ~z, alt);
        push(4'd7, C_WRG, 1'b1, ~z, alt);
      end
      OP_BR: push(4'd9, z ? C_BR1 : C_BR0, 1'b1, z, alt);
      default: ;
    endcase
  endtask

  task automatic test_reset();
    ifc.mem_ready = 1'b1; ifc.zero = 1'b1; ifc.opcode = OP_R;
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (obs_ctrl() !== C_ZERO) begin errors++; $display("FAIL reset ctrl got=%b exp=%b", obs_ctrl(), C_ZERO); end
    if (ifc.state !== 4'd0) begin errors++; $display("FAIL reset state got=%0d exp=0", ifc.state); end
    if (ifc.instret !== 16'd0) begin errors++; $display("FAIL reset instret got=%0d exp=0", ifc.instret); end
    @(negedge clk);
    rst_n = 1'b1; ifc.mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    issue(OP_R, 1'b0, 1, 0);
    issue(OP_I, 1'b1, 0, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      ifc.mem_ready = it.mr; ifc.zero = it.z; ifc.opcode = it.op;
      @(negedge clk);
      checks += 3;
      if (ifc.state !== it.st) begin errors++; $display("FAIL alu state cyc=%0d got=%0d exp=%0d", n, ifc.state, it.st); end
      if (obs_ctrl() !== it.ctrl) begin errors++; $display("FAIL alu ctrl cyc=%0d got=%b exp=%b", n, obs_ctrl(), it.ctrl); end
      if (ifc.instret !== it.ic) begin errors++; $display("FAIL alu instret cyc=%0d got=%0d exp=%0d", n, ifc.instret, it.ic); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_stall();
    issue(OP_LD, 1'b0, 0, 3);
    issue(OP_ST, 1'b1, 2, 2);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      ifc.mem_ready = it.mr; ifc.zero = it.z; ifc.opcode = it.op;
      @(negedge clk);
      checks += 3;
      if (ifc.state !== it.st) begin errors++; $display("FAIL mem state cyc=%0d got=%0d exp=%0d", n, ifc.state, it.st); end
      if (obs_ctrl() !== it.ctrl) begin errors++; $display("FAIL mem ctrl cyc=%0d got=%b exp=%b", n, obs_ctrl(), it.ctrl); end
      if (ifc.instret !== it.ic) begin errors++; $display("FAIL mem instret cyc=%0d got=%0d exp=%0d", n, ifc.instret, it.ic); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_illegal();
    issue(OP_BR, 1'b1, 0, 0);
    issue(OP_BR, 1'b0, 0, 0);
    issue(OP_BAD, 1'b0, 0, 0);
    push(4'd0, C_FW, 1'b0, 1'b0, OP_BAD);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      ifc.mem_ready = it.mr; ifc.zero = it.z; ifc.opcode = it.op;
      @(negedge clk);
      checks += 3;
      if (ifc.state !== it.st) begin errors++; $display("FAIL br state cyc=%0d got=%0d exp=%0d", n, ifc.state, it.st); end
      if (obs_ctrl() !== it.ctrl) begin errors++; $display("FAIL br ctrl cyc=%0d got=%b exp=%b", n, obs_ctrl(), it.ctrl); end
      if (ifc.instret !== it.ic) begin errors++; $display("FAIL br instret cyc=%0d got=%0d exp=%0d", n, ifc.instret, it.ic); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 5))
        0: issue(OP_R,  1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
        1: issue(OP_I,  1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
        2: issue(OP_LD, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        3: issue(OP_ST, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        4: issue(OP_BR, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
        default: issue(7'b0110111, 1'b0, 0, 0);
      endcase
    end
    while (sb.size() != 0) begin
      it = sb.pop_front();
      ifc.mem_ready = it.mr; ifc.zero = it.z; ifc.opcode = it.op;
      @(negedge clk);
      checks += 3;
      if (ifc.state !== it.st) begin errors++; $display("FAIL b2b state cyc=%0d got=%0d exp=%0d", n, ifc.state, it.st); end
      if (obs_ctrl() !== it.ctrl) begin errors++; $display("FAIL b2b ctrl cyc=%0d got=%b exp=%b", n, obs_ctrl(), it.ctrl); end
      if (ifc.instret !== it.ic) begin errors++; $display("FAIL b2b instret cyc=%0d got=%0d exp=%0d", n, ifc.instret, it.ic); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  // Counter is preset near wrap instead of retiring 65535 instructions
  task automatic test_wrap();
    ifc.mem_ready = 1'b0;
    force dut.instret_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.instret_q;
    model_instret = 16'hFFFF;
    issue(OP_R, 1'b0, 1, 0);
    push(4'd0, C_FW, 1'b0, 1'b0, OP_R);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      ifc.mem_ready = it.mr; ifc.zero = it.z; ifc.opcode = it.op;
      @(negedge clk);
      checks += 3;
      if (ifc.state !== it.st) begin errors++; $display("FAIL wrap state cyc=%0d got=%0d exp=%0d", n, ifc.state, it.st); end
      if (obs_ctrl() !== it.ctrl) begin errors++; $display("FAIL wrap ctrl cyc=%0d got=%b exp=%b", n, obs_ctrl(), it.ctrl); end
      if (ifc.instret !== it.ic) begin errors++; $display("FAIL wrap instret cyc=%0d got=%0h exp=%0h", n, ifc.instret, it.ic); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort();
    issue(OP_I, 1'b0, 0, 0);
    push(4'd0, C_FG, 1'b1, 1'b0, OP_ST);
    push(4'd1, C_DEC, 1'b1, 1'b0, OP_ST);
    push(4'd4, C_EXI, 1'b1, 1'b0, OP_LD);
    push(4'd7, C_WRW, 1'b0, 1'b0, OP_LD);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      ifc.mem_ready = it.mr; ifc.zero = it.z; ifc.opcode = it.op;
      @(negedge clk);
      checks += 3;
      if (ifc.state !== it.st) begin errors++; $display("FAIL abort state cyc=%0d got=%0d exp=%0d", n, ifc.state, it.st); end
      if (obs_ctrl() !== it.ctrl) begin errors++; $display("FAIL abort ctrl cyc=%0d got=%b exp=%b", n, obs_ctrl(), it.ctrl); end
      if (ifc.instret !== it.ic) begin errors++; $display("FAIL abort instret cyc=%0d got=%0d exp=%0d", n, ifc.instret, it.ic); end
      n++;
      @(posedge clk); #1;
    end
    // Still stalled in MEM_WR; pull reset mid-cycle
    ifc.mem_ready = 1'b0;
    #2;
    checks += 1;
    if (ifc.state !== 4'd7) begin errors++; $display("FAIL abort pre state got=%0d exp=7", ifc.state); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (obs_ctrl() !== C_ZERO) begin errors++; $display("FAIL abort async ctrl got=%b exp=%b", obs_ctrl(), C_ZERO); end
    if (ifc.state !== 4'd0) begin errors++; $display("FAIL abort async state got=%0d exp=0", ifc.state); end
    if (ifc.instret !== 16'd0) begin errors++; $display("FAIL abort async instret got=%0d exp=0", ifc.instret); end
    ifc.mem_ready = 1'b1;
    @(posedge clk); #1;
    checks += 1;
    if (obs_ctrl() !== C_ZERO) begin errors++; $display("FAIL abort held ctrl got=%b exp=%b", obs_ctrl(), C_ZERO); end
    @(negedge clk);
    rst_n = 1'b1; ifc.mem_ready = 1'b0;
    model_instret = 16'd0;
    @(posedge clk); #1;
    issue(OP_R, 1'b0, 1, 0);
    push(4'd0, C_FW, 1'b0, 1'b0, OP_R);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      ifc.mem_ready = it.mr; ifc.zero = it.z; ifc.opcode = it.op;
      @(negedge clk);
      checks += 3;
      if (ifc.state !== it.st) begin errors++; $display("FAIL post state cyc=%0d got=%0d exp=%0d", n, ifc.state, it.st); end
      if (obs_ctrl() !== it.ctrl) begin errors++; $display("FAIL post ctrl cyc=%0d got=%b exp=%b", n, obs_ctrl(), it.ctrl); end
      if (ifc.instret !== it.ic) begin errors++; $display("FAIL post instret cyc=%0d got=%0d exp=%0d", n, ifc.instret, it.ic); end
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    ifc.mem_ready = 1'b0; ifc.zero = 1'b0; ifc.opcode = 7'd0;
    test_reset();
    test_alu();
    test_load_stall();
    test_branch_illegal();
    test_back_to_back();
    test_wrap();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
